// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus of imem_fetch_ctrl: pipeline control, debug read port and
// instruction-memory port. The master drives the requests and the memory read data.
interface imem_fetch_ctrl_if;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic        dbg_req;
  logic [63:0] dbg_addr;
  logic [31:0] imem_instruction;
  logic [63:0] imem_address;
  logic [63:0] pc;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        dbg_rvalid;
  logic        dbg_err;
  logic        fault;

  modport master (
    output stall, br_taken, br_target, dbg_req, dbg_addr, imem_instruction,
    input  imem_address, pc, instr_out, instr_valid, dbg_gnt, dbg_rdata,
           dbg_rvalid, dbg_err, fault
  );

  modport slave (
    input  stall, br_taken, br_target, dbg_req, dbg_addr, imem_instruction,
    output imem_address, pc, instr_out, instr_valid, dbg_gnt, dbg_rdata,
           dbg_rvalid, dbg_err, fault
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: sequential fetch into the IF/ID register, branch
// redirect, illegal-fetch halt and a starvation-bounded debug read port.
module imem_fetch_ctrl #(
  parameter int unsigned MEM_SIZE     = 1024,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            reset_n,
  imem_fetch_ctrl_if.slave bus
);

  localparam int unsigned CW        = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [63:0] LAST_WORD = 64'(MEM_SIZE - 4);
  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DBG, S_HALT} state_e;

  state_e        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          ivalid_q, ivalid_d;
  logic [63:0]   dbg_addr_q, dbg_addr_d;
  logic [31:0]   dbg_rdata_q, dbg_rdata_d;
  logic          dbg_rvalid_q, dbg_rvalid_d;
  logic          dbg_err_q, dbg_err_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          gnt;
  logic [63:0]   imem_addr;

  // Comparing against the last word address keeps addr+3 from wrapping.
  function automatic logic addr_legal(input logic [63:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_WORD);
  endfunction

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    ivalid_d     = ivalid_q;
    dbg_addr_d   = dbg_addr_q;
    dbg_rdata_d  = dbg_rdata_q;
    dbg_rvalid_d = 1'b0;
    dbg_err_d    = dbg_err_q;
    fault_d      = fault_q;
    gnt          = 1'b0;
    imem_addr    = fetch_pc_q;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        gnt = bus.dbg_req && !bus.br_taken && (bus.stall || (starve_q == LIMIT));
        if (bus.br_taken) begin
          fetch_pc_d = bus.br_target;
          ivalid_d   = 1'b0;
        end else begin
          if (!addr_legal(fetch_pc_q)) begin
            fault_d  = 1'b1;
            ivalid_d = 1'b0;
            state_d  = S_HALT;
          end else if (!bus.stall) begin
            instr_d    = bus.imem_instruction;
            pc_d       = fetch_pc_q;
            ivalid_d   = 1'b1;
            fetch_pc_d = fetch_pc_q + 64'd4;
          end
          // A grant still lets this cycle's fetch complete; the DBG cycle is the bubble.
          // With a fault already raised, DBG hands over to HALT afterwards.
          if (gnt) begin
            state_d    = S_DBG;
            dbg_addr_d = bus.dbg_addr;
          end
        end
      end

      S_DBG: begin
        imem_addr    = dbg_addr_q;
        dbg_rdata_d  = addr_legal(dbg_addr_q) ? bus.imem_instruction : '0;
        dbg_err_d    = !addr_legal(dbg_addr_q);
        dbg_rvalid_d = 1'b1;
        if (!bus.stall) ivalid_d = 1'b0;
        state_d = fault_q ? S_HALT : S_FETCH;
      end

      S_HALT: begin
        gnt      = bus.dbg_req;
        ivalid_d = 1'b0;
        if (gnt) begin
          state_d    = S_DBG;
          dbg_addr_d = bus.dbg_addr;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (bus.dbg_req && !gnt) begin
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + CW'(1);
    end else begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= '0;
      pc_q         <= '0;
      instr_q      <= '0;
      ivalid_q     <= 1'b0;
      dbg_addr_q   <= '0;
      dbg_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_err_q    <= 1'b0;
      fault_q      <= 1'b0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      ivalid_q     <= ivalid_d;
      dbg_addr_q   <= dbg_addr_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_err_q    <= dbg_err_d;
      fault_q      <= fault_d;
      starve_q     <= starve_d;
    end
  end

  assign bus.imem_address = imem_addr;
  assign bus.pc           = pc_q;
  assign bus.instr_out    = instr_q;
  assign bus.instr_valid  = ivalid_q;
  assign bus.dbg_gnt      = gnt;
  assign bus.dbg_rdata    = dbg_rdata_q;
  assign bus.dbg_rvalid   = dbg_rvalid_q;
  assign bus.dbg_err      = dbg_err_q;
  assign bus.fault        = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed stimulus pushes expected fetches and
// debug reads; a negedge monitor pops and compares whenever the DUT presents them.
module tb_imem_fetch_ctrl;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } fexp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } dexp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] mem [256];
  fexp_t       fq[$];
  dexp_t       dq[$];
  int          tests = 0;
  int          failed = 0;

  imem_fetch_ctrl_if bus ();

  imem_fetch_ctrl #(.MEM_SIZE(1024), .STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (bus.imem_address < 64'd1024) bus.imem_instruction = mem[bus.imem_address[9:2]];
    else                             bus.imem_instruction = 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushf(input logic [63:0] p, input logic [31:0] i);
    fexp_t e;
    e.pc = p;
    e.instr = i;
    fq.push_back(e);
  endtask

  task automatic pushd(input logic [31:0] d, input logic e);
    dexp_t x;
    x.rdata = d;
    x.err = e;
    dq.push_back(x);
  endtask

  // Monitor: a new instruction is a valid word whose pc differs from the last one shown.
  initial begin
    logic        pv;
    logic        prv;
    logic [63:0] ppc;
    fexp_t       fe;
    dexp_t       de;
    pv = 1'b0; prv = 1'b0; ppc = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pv = 1'b0;
        prv = 1'b0;
      end else begin
        if (bus.instr_valid && (!pv || bus.pc != ppc)) begin
          if (fq.size() == 0) begin
            tests++; failed++;
            $display("FAIL fetch_unexpected: got pc 0x%0h instr 0x%0h, expected none", bus.pc, bus.instr_out);
          end else begin
            fe = fq.pop_front();
            check("fetch_pc", bus.pc, fe.pc);
            check("fetch_instr", 64'(bus.instr_out), 64'(fe.instr));
          end
        end
        if (bus.dbg_rvalid) begin
          check("rvalid_single_pulse", 64'(prv), 64'd0);
          if (dq.size() == 0) begin
            tests++; failed++;
            $display("FAIL dbg_unexpected: got rdata 0x%0h err %0b, expected none", bus.dbg_rdata, bus.dbg_err);
          end else begin
            de = dq.pop_front();
            check("dbg_rdata", 64'(bus.dbg_rdata), 64'(de.rdata));
            check("dbg_err", 64'(bus.dbg_err), 64'(de.err));
          end
        end
        pv = bus.instr_valid;
        ppc = bus.pc;
        prv = bus.dbg_rvalid;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[0] = 32'hAAAA_0000;
    mem[1] = 32'hBBBB_0001;
    mem[2] = 32'hCCCC_0002;
    mem[3] = 32'hDDDD_0003;
    bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
    bus.dbg_req = 1'b0; bus.dbg_addr = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_pc", bus.pc, 64'd0);
    check("rst_instr", 64'(bus.instr_out), 64'd0);
    check("rst_addr", bus.imem_address, 64'd0);
    check("rst_fault", 64'(bus.fault), 64'd0);
    check("rst_rvalid", 64'(bus.dbg_rvalid), 64'd0);

    // Sequential fetch after reset
    pushf(64'h0, 32'hAAAA_0000); pushf(64'h4, 32'hBBBB_0001);
    pushf(64'h8, 32'hCCCC_0002); pushf(64'hC, 32'hDDDD_0003);
    @(posedge clk); #1 reset_n = 1'b1;
    tick(); #1;
    check("idle_no_fetch", 64'(bus.instr_valid), 64'd0);
    repeat (4) tick();

    // Branch back to 0, then to 0x40 from pc=8 with stall also high
    bus.br_taken = 1'b1; bus.br_target = 64'h0;
    tick(); bus.br_taken = 1'b0; #1;
    check("br0_bubble", 64'(bus.instr_valid), 64'd0);
    pushf(64'h0, 32'hAAAA_0000); pushf(64'h4, 32'hBBBB_0001); pushf(64'h8, 32'hCCCC_0002);
    repeat (3) tick();
    bus.br_taken = 1'b1; bus.br_target = 64'h40; bus.stall = 1'b1; #1;
    check("br_no_gnt", 64'(bus.dbg_gnt), 64'd0);
    tick(); bus.br_taken = 1'b0; bus.stall = 1'b0; #1;
    check("br_bubble", 64'(bus.instr_valid), 64'd0);
    check("br_pc_hold", bus.pc, 64'h8);
    pushf(64'h40, 32'hC0DE_0010);
    tick();

    // Debug read granted during stall
    bus.stall = 1'b1; bus.dbg_req = 1'b1; bus.dbg_addr = 64'h10;
    pushd(32'hC0DE_0004, 1'b0); #1;
    check("stall_gnt", 64'(bus.dbg_gnt), 64'd1);
    check("stall_fetch_addr", bus.imem_address, 64'h44);
    tick(); bus.dbg_req = 1'b0; #1;
    check("dbg_port_addr", bus.imem_address, 64'h10);
    check("dbg_no_gnt", 64'(bus.dbg_gnt), 64'd0);
    check("stall_pc1", bus.pc, 64'h40);
    check("stall_instr1", 64'(bus.instr_out), 64'hC0DE_0010);
    check("stall_valid1", 64'(bus.instr_valid), 64'd1);
    tick(); #1;
    check("stall_rvalid", 64'(bus.dbg_rvalid), 64'd1);
    check("stall_pc2", bus.pc, 64'h40);
    check("stall_instr2", 64'(bus.instr_out), 64'hC0DE_0010);
    tick(); #1;
    check("stall_rvalid_drop", 64'(bus.dbg_rvalid), 64'd0);
    check("stall_pc3", bus.pc, 64'h40);
    bus.stall = 1'b0;
    pushf(64'h44, 32'hC0DE_0011);
    tick();

    // Starvation-forced grant on the fifth request cycle
    pushf(64'h48, 32'hC0DE_0012); pushf(64'h4C, 32'hC0DE_0013); pushf(64'h50, 32'hC0DE_0014);
    pushf(64'h54, 32'hC0DE_0015); pushf(64'h58, 32'hC0DE_0016); pushf(64'h5C, 32'hC0DE_0017);
    pushd(32'hCCCC_0002, 1'b0);
    bus.dbg_req = 1'b1; bus.dbg_addr = 64'h8;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("starve_gnt", 64'(bus.dbg_gnt), 64'(k == 4));
      tick();
    end
    bus.dbg_req = 1'b0; #1;
    check("forced_dbg_addr", bus.imem_address, 64'h8);
    tick(); #1;
    check("forced_bubble", 64'(bus.instr_valid), 64'd0);
    check("forced_pc_hold", bus.pc, 64'h58);
    tick(); #1;
    check("forced_resume", 64'(bus.instr_valid), 64'd1);

    // Misaligned branch target -> HALT, then debug read of the same address
    bus.br_taken = 1'b1; bus.br_target = 64'h3FE;
    tick(); bus.br_taken = 1'b0; #1;
    check("mis_bubble", 64'(bus.instr_valid), 64'd0);
    check("mis_addr", bus.imem_address, 64'h3FE);
    tick(); #1;
    check("mis_fault", 64'(bus.fault), 64'd1);
    check("mis_valid", 64'(bus.instr_valid), 64'd0);
    tick(); #1;
    check("halt_fault_sticky", 64'(bus.fault), 64'd1);
    bus.dbg_req = 1'b1; bus.dbg_addr = 64'h3FE;
    pushd(32'h0, 1'b1); #1;
    check("halt_gnt", 64'(bus.dbg_gnt), 64'd1);
    tick(); bus.dbg_req = 1'b0; #1;
    check("halt_dbg_addr", bus.imem_address, 64'h3FE);
    tick(); #1;
    check("halt_after_dbg_fault", 64'(bus.fault), 64'd1);
    check("halt_after_dbg_valid", 64'(bus.instr_valid), 64'd0);

    // Reset asserted mid-DBG drops the read
    bus.dbg_req = 1'b1; bus.dbg_addr = 64'hC; #1;
    check("halt_gnt2", 64'(bus.dbg_gnt), 64'd1);
    tick(); bus.dbg_req = 1'b0; #1;
    reset_n = 1'b0; #1;
    check("mid_rst_addr", bus.imem_address, 64'd0);
    check("mid_rst_pc", bus.pc, 64'd0);
    check("mid_rst_instr", 64'(bus.instr_out), 64'd0);
    check("mid_rst_valid", 64'(bus.instr_valid), 64'd0);
    check("mid_rst_err", 64'(bus.dbg_err), 64'd0);
    check("mid_rst_fault", 64'(bus.fault), 64'd0);
    check("mid_rst_rvalid", 64'(bus.dbg_rvalid), 64'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("mid_rst_no_rvalid", 64'(bus.dbg_rvalid), 64'd0);
    end
    pushf(64'h0, 32'hAAAA_0000); pushf(64'h4, 32'hBBBB_0001);
    reset_n = 1'b1;
    tick(); #1;
    check("rst2_idle", 64'(bus.instr_valid), 64'd0);
    tick(); tick();

    // Branch to MEM_SIZE -> HALT, then debug read of the last legal word
    bus.br_taken = 1'b1; bus.br_target = 64'h400;
    tick(); bus.br_taken = 1'b0;
    tick(); #1;
    check("oob_fault", 64'(bus.fault), 64'd1);
    check("oob_valid", 64'(bus.instr_valid), 64'd0);
    check("oob_pc_hold", bus.pc, 64'h4);
    bus.dbg_req = 1'b1; bus.dbg_addr = 64'h3FC;
    pushd(32'hC0DE_00FF, 1'b0); #1;
    check("oob_gnt", 64'(bus.dbg_gnt), 64'd1);
    tick(); bus.dbg_req = 1'b0; #1;
    check("last_word_addr", bus.imem_address, 64'h3FC);
    repeat (4) tick();

    check("fetch_queue_drained", 64'(fq.size()), 64'd0);
    check("dbg_queue_drained", 64'(dq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
